// File: rtl/message_scroller_if.sv
// Bundle of the scroller's control inputs and display-window outputs.
// The slave side is the scroller itself; the master side drives button,
// auto-scroll enable and direction, and observes the window.
interface message_scroller_if;
  logic        button;
  logic        auto_en;
  logic        dir;
  logic [15:0] chars;
  logic [3:0]  ptr;
  logic        step_pulse;

  modport master (
    output button, auto_en, dir,
    input  chars, ptr, step_pulse
  );

  modport slave (
    input  button, auto_en, dir,
    output chars, ptr, step_pulse
  );
endinterface

// File: rtl/message_scroller.sv
// Message scroller: presents a 4-character window of a fixed message to the
// LED display path. The window moves one position per debounced button press
// or per auto-scroll timer tick, forward or backward, wrapping at both ends.
module message_scroller #(
  parameter int          MSG_LEN         = 16,
  parameter logic [63:0] MESSAGE         = 64'hFEDCBA9876543210,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          AUTO_PERIOD     = 16
) (
  input  logic              clk,
  input  logic              reset,
  message_scroller_if.slave bus
);

  localparam int                CNT_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int                TMR_W       = $clog2(AUTO_PERIOD);
  localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(AUTO_PERIOD - 1);
  localparam logic [3:0]        PTR_LAST    = 4'(MSG_LEN - 1);
  // Window at ptr=0; MSG_LEN is at least 4, so no wrap is involved here.
  localparam logic [15:0]       RESET_CHARS = {MESSAGE[3:0], MESSAGE[7:4],
                                               MESSAGE[11:8], MESSAGE[15:12]};

  // Forward neighbour of an index, wrapping at the end of the message.
  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == PTR_LAST) ? 4'd0 : p + 4'd1;
  endfunction

  // Backward neighbour of an index, wrapping at the start of the message.
  function automatic logic [3:0] ptr_dec(input logic [3:0] p);
    return (p == 4'd0) ? PTR_LAST : p - 4'd1;
  endfunction

  // Character code stored at a message index.
  function automatic logic [3:0] char_at(input logic [3:0] idx);
    return MESSAGE[{idx, 2'b00} +: 4];
  endfunction

  // Four consecutive characters starting at p, leftmost digit first.
  function automatic logic [15:0] window(input logic [3:0] p);
    logic [3:0] p1;
    logic [3:0] p2;
    logic [3:0] p3;
    p1 = ptr_inc(p);
    p2 = ptr_inc(p1);
    p3 = ptr_inc(p2);
    return {char_at(p), char_at(p1), char_at(p2), char_at(p3)};
  endfunction

  logic             s1_q;
  logic             s2_q;
  logic             deb_level_q, deb_level_d;
  logic [CNT_W-1:0] deb_cnt_q,   deb_cnt_d;
  logic             deb_prev_q;
  logic [TMR_W-1:0] tmr_q,       tmr_d;
  logic [3:0]       ptr_q,       ptr_d;
  logic [15:0]      chars_q,     chars_d;
  logic             step_q,      step_d;
  logic             press_s;
  logic             tick_s;

  // Accept a new button level only after it has differed on DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = {CNT_W{1'b0}};
    if (s2_q != deb_level_q) begin
      if (deb_cnt_q == CNT_LAST) begin
        deb_level_d = s2_q;
        deb_cnt_d   = {CNT_W{1'b0}};
      end else begin
        deb_cnt_d   = deb_cnt_q + CNT_W'(1);
      end
    end else begin
      deb_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Press on the debounced rising level, tick at the end of each auto period, and the resulting step/window.
  always_comb begin
    press_s = deb_level_q & ~deb_prev_q;
    tick_s  = bus.auto_en & (tmr_q == TMR_LAST);
    step_d  = press_s | tick_s;
    // A manual press restarts the auto period; disabling auto holds the timer at zero.
    if (!bus.auto_en || press_s || tick_s) begin
      tmr_d = {TMR_W{1'b0}};
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end
    if (step_d) begin
      if (bus.dir) begin
        ptr_d = ptr_dec(ptr_q);
      end else begin
        ptr_d = ptr_inc(ptr_q);
      end
    end else begin
      ptr_d = ptr_q;
    end
    chars_d = window(ptr_d);
  end

  // State registers: synchroniser, debounce, edge history, timer and the registered window outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      deb_level_q <= 1'b0;
      deb_cnt_q   <= {CNT_W{1'b0}};
      deb_prev_q  <= 1'b0;
      tmr_q       <= {TMR_W{1'b0}};
      ptr_q       <= 4'd0;
      chars_q     <= RESET_CHARS;
      step_q      <= 1'b0;
    end else begin
      s1_q        <= bus.button;
      s2_q        <= s1_q;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_prev_q  <= deb_level_q;
      tmr_q       <= tmr_d;
      ptr_q       <= ptr_d;
      chars_q     <= chars_d;
      step_q      <= step_d;
    end
  end

  assign bus.chars      = chars_q;
  assign bus.ptr        = ptr_q;
  assign bus.step_pulse = step_q;

endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller: a 16-character instance and a
// 5-character instance share clock and reset; expected values are hand-derived.
module tb_message_scroller;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  message_scroller_if bus_a ();
  message_scroller_if bus_b ();

  message_scroller u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  message_scroller #(.MSG_LEN(5)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;
  int steps_a  = 0;
  int base;

  // Count scroll steps of the 16-character instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_a.step_pulse === 1'b1) steps_a <= steps_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    bus_a.button  = 1'b0;
    bus_a.auto_en = 1'b0;
    bus_a.dir     = 1'b0;
    bus_b.button  = 1'b0;
    bus_b.auto_en = 1'b0;
    bus_b.dir     = 1'b0;
    cyc(2);
    chk("rst_ptr",     32'(bus_a.ptr),        32'h0);
    chk("rst_chars",   32'(bus_a.chars),      32'h0123);
    chk("rst_step",    32'(bus_a.step_pulse), 32'h0);
    chk("rst_b_chars", 32'(bus_b.chars),      32'h0123);

    // Clean press: button first sampled on edge 1, step lands on edge 7.
    reset        = 1'b1;
    bus_a.button = 1'b1;
    cyc(6);
    chk("press_e6_ptr",  32'(bus_a.ptr),        32'h0);
    chk("press_e6_step", 32'(bus_a.step_pulse), 32'h0);
    cyc(1);
    chk("press_e7_ptr",   32'(bus_a.ptr),        32'h1);
    chk("press_e7_chars", 32'(bus_a.chars),      32'h1234);
    chk("press_e7_step",  32'(bus_a.step_pulse), 32'h1);
    cyc(1);
    chk("press_e8_step", 32'(bus_a.step_pulse), 32'h0);
    cyc(42);
    bus_a.button = 1'b0;
    cyc(30);
    chk("press_once",     32'(steps_a),   32'h1);
    chk("press_hold_ptr", 32'(bus_a.ptr), 32'h1);

    // Reset mid-run with a debounce count pending.
    bus_a.button = 1'b1;
    cyc(4);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ptr",   32'(bus_a.ptr),        32'h0);
    chk("midrst_chars", 32'(bus_a.chars),      32'h0123);
    chk("midrst_step",  32'(bus_a.step_pulse), 32'h0);
    bus_a.button = 1'b0;
    cyc(3);
    reset = 1'b1;
    base  = steps_a;
    cyc(100);
    chk("idle_steps", 32'(steps_a - base), 32'h0);
    chk("idle_ptr",   32'(bus_a.ptr),      32'h0);
    chk("idle_chars", 32'(bus_a.chars),    32'h0123);

    // Bounce: 3-cycle highs separated by 1-cycle lows never qualify.
    base = steps_a;
    for (int i = 0; i < 10; i++) begin
      bus_a.button = 1'b1;
      cyc(3);
      bus_a.button = 1'b0;
      cyc(1);
    end
    cyc(20);
    chk("bounce_steps", 32'(steps_a - base), 32'h0);
    chk("bounce_ptr",   32'(bus_a.ptr),      32'h0);
    bus_a.button = 1'b1;
    cyc(30);
    chk("bounce_hold_steps", 32'(steps_a - base), 32'h1);
    chk("bounce_hold_ptr",   32'(bus_a.ptr),      32'h1);
    bus_a.button = 1'b0;
    cyc(20);
    chk("bounce_rel_steps", 32'(steps_a - base), 32'h1);

    // Backward wrap from ptr=0.
    reset = 1'b0;
    cyc(2);
    reset     = 1'b1;
    bus_a.dir = 1'b1;
    bus_a.button = 1'b1;
    cyc(12);
    bus_a.button = 1'b0;
    cyc(12);
    chk("back1_ptr",   32'(bus_a.ptr),   32'hF);
    chk("back1_chars", 32'(bus_a.chars), 32'hF012);
    bus_a.button = 1'b1;
    cyc(12);
    bus_a.button = 1'b0;
    cyc(12);
    chk("back2_ptr",   32'(bus_a.ptr),   32'hE);
    chk("back2_chars", 32'(bus_a.chars), 32'hEF01);
    bus_a.dir = 1'b0;

    // Auto-scroll on both instances: one tick every 16 edges.
    reset = 1'b0;
    cyc(2);
    chk("auto_rst_b_ptr", 32'(bus_b.ptr), 32'h0);
    reset         = 1'b1;
    bus_a.auto_en = 1'b1;
    bus_b.auto_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc(15);
      chk("auto_gap_step", 32'(bus_a.step_pulse), 32'h0);
      cyc(1);
      chk("auto_tick_step", 32'(bus_a.step_pulse), 32'h1);
      chk("auto_ptr",       32'(bus_a.ptr),        32'(k % 16));
      chk("auto_b_ptr",     32'(bus_b.ptr),        32'(k % 5));
      if (k == 3)  chk("short_p3_chars",  32'(bus_b.chars), 32'h3401);
      if (k == 4)  chk("short_p4_chars",  32'(bus_b.chars), 32'h4012);
      if (k == 5)  chk("short_wrap",      32'(bus_b.chars), 32'h0123);
      if (k == 15) chk("auto_p15_chars",  32'(bus_a.chars), 32'hF012);
      if (k == 16) chk("auto_wrap_chars", 32'(bus_a.chars), 32'h0123);
    end
    // Disable on the cycle a tick is pending: that tick must not happen.
    cyc(15);
    bus_a.auto_en = 1'b0;
    bus_b.auto_en = 1'b0;
    cyc(1);
    chk("auto_off_step", 32'(bus_a.step_pulse), 32'h0);
    chk("auto_off_ptr",  32'(bus_a.ptr),        32'h0);
    base = steps_a;
    cyc(40);
    chk("auto_off_steps", 32'(steps_a - base), 32'h0);

    // Collision: press and tick both land on edge 16.
    reset = 1'b0;
    cyc(2);
    reset         = 1'b1;
    bus_a.auto_en = 1'b1;
    cyc(9);
    bus_a.button = 1'b1;
    cyc(6);
    chk("coll_e15_step", 32'(bus_a.step_pulse), 32'h0);
    chk("coll_e15_ptr",  32'(bus_a.ptr),        32'h0);
    cyc(1);
    chk("coll_e16_step",  32'(bus_a.step_pulse), 32'h1);
    chk("coll_e16_ptr",   32'(bus_a.ptr),        32'h1);
    chk("coll_e16_chars", 32'(bus_a.chars),      32'h1234);
    cyc(1);
    chk("coll_e17_step", 32'(bus_a.step_pulse), 32'h0);
    chk("coll_e17_ptr",  32'(bus_a.ptr),        32'h1);
    bus_a.button = 1'b0;
    cyc(14);
    chk("coll_e31_step", 32'(bus_a.step_pulse), 32'h0);
    cyc(1);
    chk("coll_e32_step", 32'(bus_a.step_pulse), 32'h1);
    chk("coll_e32_ptr",  32'(bus_a.ptr),        32'h2);
    bus_a.auto_en = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
